// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder: default data width and the
// add/subtract mode encoding.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

package pipe_adder_pkg;

  localparam int LEN_DATA = `LEN_DATA;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result bundle for the pipelined adder. The master side issues
// operands, the slave side (the adder) returns results.
interface pipe_adder_if
  import pipe_adder_pkg::*;
  #(parameter int WIDTH = LEN_DATA);

  logic             en;
  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             rdy;

  modport master (
    output en, valid, a, b, sub, cin,
    input  sum, cout, ovf, rdy
  );

  modport slave (
    input  en, valid, a, b, sub, cin,
    output sum, cout, ovf, rdy
  );

endinterface

// File: rtl/pipe_adder_seg.sv
// One carry segment of the pipelined adder: W-bit add with carry in/out and
// a signed-overflow tap taken at the segment MSB (only meaningful on the
// most significant segment).
module adder_seg
  import pipe_adder_pkg::*;
  #(parameter int W = 16)
  (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ovf
  );

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign ovf     = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);

endmodule

// File: rtl/pipe_adder.sv
// Carry-segmented pipelined adder/subtractor. Stage k adds segment k and
// hands its carry to stage k+1. Operands still waiting for their segment
// ride along in the per-stage operand registers (skew), and finished
// segments accumulate in the per-stage partial-sum register (de-skew), so
// the whole result leaves the last stage at once. Stage 0 works directly on
// the inputs, which gives a latency of STAGES enabled edges.
module pipe_adder
  import pipe_adder_pkg::*;
  #(
    parameter int WIDTH  = LEN_DATA,
    parameter int STAGES = 4
  )
  (
    input  logic          clk,
    input  logic          rst,
    pipe_adder_if.slave   bus
  );

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: STAGES must be 1..WIDTH and divide WIDTH");
  end

  // Values presented to each stage (stage 0 from the inputs, others from
  // the previous stage register).
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  // Stage output registers; the last one is the result register.
  logic [WIDTH-1:0] pr_a [STAGES];
  logic [WIDTH-1:0] pr_b [STAGES];
  logic [WIDTH-1:0] pr_s [STAGES];
  logic             pr_c [STAGES];
  logic             pr_v [STAGES];
  logic             ovf_r;

  logic [SEG-1:0]   seg_sum [STAGES];
  logic             seg_co  [STAGES];
  logic             seg_ovf [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_in
      // Subtraction is a + ~b + 1; cin is ignored in that mode.
      assign st_a[0] = bus.a;
      assign st_b[0] = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
      assign st_c[0] = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
      assign st_s[0] = '0;
      assign st_v[0] = bus.valid;
    end else begin : g_link
      assign st_a[k] = pr_a[k-1];
      assign st_b[k] = pr_b[k-1];
      assign st_s[k] = pr_s[k-1];
      assign st_c[k] = pr_c[k-1];
      assign st_v[k] = pr_v[k-1];
    end

    adder_seg #(.W(SEG)) u_seg (
      .a   (st_a[k][k*SEG +: SEG]),
      .b   (st_b[k][k*SEG +: SEG]),
      .ci  (st_c[k]),
      .s   (seg_sum[k]),
      .co  (seg_co[k]),
      .ovf (seg_ovf[k])
    );
  end

  // Advance all stages on en; data registers only load for valid slots so a
  // bubble leaves the previous result standing at the output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        pr_a[k] <= '0;
        pr_b[k] <= '0;
        pr_s[k] <= '0;
        pr_c[k] <= 1'b0;
        pr_v[k] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (bus.en) begin
      for (int k = 0; k < STAGES; k++) begin
        pr_v[k] <= st_v[k];
        if (st_v[k]) begin
          pr_a[k]                  <= st_a[k];
          pr_b[k]                  <= st_b[k];
          pr_s[k]                  <= st_s[k];
          pr_s[k][k*SEG +: SEG]    <= seg_sum[k];
          pr_c[k]                  <= seg_co[k];
        end
      end
      if (st_v[STAGES-1]) begin
        ovf_r <= seg_ovf[STAGES-1];
      end
    end
  end

  assign bus.sum  = pr_s[STAGES-1];
  assign bus.cout = pr_c[STAGES-1];
  assign bus.ovf  = ovf_r;
  assign bus.rdy  = pr_v[STAGES-1];

endmodule
